// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and DOUT field positions for the PmodJSTK2 scheduler.
package jstk_pkg;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_SETLED = 8'h84;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_XFER,
    S_CAPTURE,
    S_ABORT,
    S_GAP
  } state_e;

  // Field positions inside the 40-bit DOUT word (byte 1 in [39:32]).
  localparam int X_LO_MSB = 39;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_MSB = 25;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_MSB = 23;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_MSB = 9;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_MSB  = 1;
  localparam int BTN_LSB  = 0;

  function automatic logic [39:0] led_cmd(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    return {CMD_SETLED, r, g, b, 8'h00};
  endfunction

endpackage

// File: rtl/jstk_poll_sched_if.sv
// Host / spiCtrl facing signals of the scheduler, bundled as one interface.
interface jstk_poll_sched_if;
  logic        ledReq;
  logic [7:0]  ledR;
  logic [7:0]  ledG;
  logic [7:0]  ledB;
  logic        ledAck;
  logic        SS;
  logic [39:0] DOUT;
  logic        sndRec;
  logic [39:0] DIN;
  logic [9:0]  posX;
  logic [9:0]  posY;
  logic [1:0]  btns;
  logic        dataValid;
  logic        err;

  // Scheduler side.
  modport master (
    input  ledReq, ledR, ledG, ledB, SS, DOUT,
    output ledAck, sndRec, DIN, posX, posY, btns, dataValid, err
  );

  // Host plus spiCtrl side.
  modport slave (
    output ledReq, ledR, ledG, ledB, SS, DOUT,
    input  ledAck, sndRec, DIN, posX, posY, btns, dataValid, err
  );
endinterface

// File: rtl/jstk_tick_gen.sv
// Free-running 0..POLL_DIV-1 counter; tick is high in the cycle the counter wraps.
module jstk_tick_gen #(
  parameter int POLL_DIV = 3334
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = $clog2(POLL_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(POLL_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count with wrap at POLL_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/jstk_poll_sched.sv
// Sequences 5-byte PmodJSTK2 exchanges through spiCtrl: periodic polls, LED writes
// with priority, completion via SS, and decode of the returned position bytes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | sndRec low, arbitrate LED request vs pending poll
// START   | sndRec high, waiting for spiCtrl to drop SS
// XFER    | sndRec high, bytes shifting, waiting for SS to rise
// CAPTURE | sndRec high one cycle, decode DOUT, pulse dataValid/ledAck
// ABORT   | one cycle, sticky err set, nothing else updated
// GAP     | sndRec low GAP_CYC cycles so spiCtrl returns to its Idle
module jstk_poll_sched
  import jstk_pkg::*;
#(
  parameter int POLL_DIV = 3334,
  parameter int TIMEOUT  = 1023,
  parameter int GAP_CYC  = 2
) (
  input  logic               CLK,
  input  logic               RST,
  jstk_poll_sched_if.master  bus
);

  // One counter serves the START/XFER timeout and the GAP length.
  localparam int TMR_TOP = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int TW      = $clog2(TMR_TOP + 1);
  localparam logic [TW-1:0] TMR_LIM = TW'(TIMEOUT);
  localparam logic [TW-1:0] GAP_END = TW'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
  logic        timed_out;
  logic        pend_q, pend_d;
  logic        is_led_q, is_led_d;
  logic        snd_q, snd_d;
  logic [39:0] din_q, din_d;
  logic [9:0]  pos_x_q, pos_x_d;
  logic [9:0]  pos_y_q, pos_y_d;
  logic [1:0]  btns_q, btns_d;
  logic        dv_q, dv_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        tick;
  logic        unused_dout;

  jstk_tick_gen #(.POLL_DIV(POLL_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Next-state, command load, decode and pulse generation.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pend_d    = pend_q | tick;
    is_led_d  = is_led_q;
    snd_d     = snd_q;
    din_d     = din_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    btns_d    = btns_q;
    dv_d      = 1'b0;
    ack_d     = 1'b0;
    err_d     = err_q;
    tmr_inc   = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
    timed_out = (tmr_q == TMR_LIM);

    case (state_q)
      S_IDLE: begin
        if (bus.ledReq) begin
          state_d  = S_START;
          snd_d    = 1'b1;
          din_d    = led_cmd(bus.ledR, bus.ledG, bus.ledB);
          is_led_d = 1'b1;
          tmr_d    = '0;
          pend_d   = 1'b0;   // an LED exchange also returns a fresh position
        end else if (pend_q) begin
          state_d  = S_START;
          snd_d    = 1'b1;
          din_d    = {5{CMD_NOP}};
          is_led_d = 1'b0;
          tmr_d    = '0;
          pend_d   = 1'b0;
        end
      end
      S_START: begin
        if (!bus.SS) begin
          state_d = S_XFER;
          tmr_d   = '0;
        end else if (timed_out) begin
          state_d = S_ABORT;
          snd_d   = 1'b0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_XFER: begin
        if (bus.SS) begin
          state_d = S_CAPTURE;
        end else if (timed_out) begin
          state_d = S_ABORT;
          snd_d   = 1'b0;
        end else begin
          tmr_d = tmr_inc;
        end
      end
      S_CAPTURE: begin
        // sndRec is still high here, so DOUT is guaranteed stable.
        pos_x_d = {bus.DOUT[X_HI_MSB:X_HI_LSB], bus.DOUT[X_LO_MSB:X_LO_LSB]};
        pos_y_d = {bus.DOUT[Y_HI_MSB:Y_HI_LSB], bus.DOUT[Y_LO_MSB:Y_LO_LSB]};
        btns_d  = bus.DOUT[BTN_MSB:BTN_LSB];
        dv_d    = 1'b1;
        ack_d   = is_led_q;
        snd_d   = 1'b0;
        tmr_d   = '0;
        state_d = S_GAP;
      end
      S_ABORT: begin
        // ledReq stays asserted, so a failed LED write is retried from IDLE.
        err_d   = 1'b1;
        tmr_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tmr_q == GAP_END) state_d = S_IDLE;
        else                  tmr_d   = tmr_inc;
      end
      default: begin
        state_d = S_IDLE;
        snd_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops sndRec without a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      pend_q   <= 1'b0;
      is_led_q <= 1'b0;
      snd_q    <= 1'b0;
      din_q    <= '0;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      btns_q   <= '0;
      dv_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      pend_q   <= pend_d;
      is_led_q <= is_led_d;
      snd_q    <= snd_d;
      din_q    <= din_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      btns_q   <= btns_d;
      dv_q     <= dv_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign bus.sndRec    = snd_q;
  assign bus.DIN       = din_q;
  assign bus.posX      = pos_x_q;
  assign bus.posY      = pos_y_q;
  assign bus.btns      = btns_q;
  assign bus.dataValid = dv_q;
  assign bus.ledAck    = ack_q;
  assign bus.err       = err_q;

  // DOUT bits carrying no position or button information.
  assign unused_dout = ^{bus.DOUT[31:26], bus.DOUT[15:10], bus.DOUT[7:2]};

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Directed bench for jstk_poll_sched with a behavioural spiCtrl model.
module tb_jstk_poll_sched;

  localparam int POLL_DIV = 16;
  localparam int TIMEOUT  = 20;
  localparam int GAP_CYC  = 2;

  logic clk;
  logic rst;

  jstk_poll_sched_if u_if();

  jstk_poll_sched #(.POLL_DIV(POLL_DIV), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) u_dut (
    .CLK (clk),
    .RST (rst),
    .bus (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_asrt = 0;
  int n_fail = 0;

  // Posedge counter used for all timestamps.
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // spiCtrl model: SS falls two cycles after sndRec, rises with DOUT five cycles later.
  logic [39:0] resp = '0;
  logic [39:0] din_seen = '0;
  bit          hang = 1'b0;
  int          t_ss_rise = 0;
  initial begin
    int mstate = 0;
    int mcnt = 0;
    u_if.SS = 1'b1;
    u_if.DOUT = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mstate = 0;
        u_if.SS = 1'b1;
      end else begin
        case (mstate)
          0: if (u_if.sndRec && !hang) begin mcnt = 0; mstate = 1; end
          1: begin
            mcnt++;
            if (mcnt == 2) begin u_if.SS = 1'b0; din_seen = u_if.DIN; mcnt = 0; mstate = 2; end
          end
          2: begin
            mcnt++;
            if (mcnt == 5) begin u_if.DOUT = resp; u_if.SS = 1'b1; t_ss_rise = cyc; mstate = 3; end
          end
          default: if (!u_if.sndRec) mstate = 0;
        endcase
      end
    end
  end

  // Output monitor: pulse counts, sndRec edges, low-gap and DIN stability.
  int n_dv = 0, n_ack = 0, n_rise = 0, n_fall = 0;
  int t_rise = 0, t_fall = 0, low_cnt = 100, gap_viol = 0, din_viol = 0;
  logic [39:0] din_ref = '0;
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (u_if.dataValid) n_dv++;
      if (u_if.ledAck) n_ack++;
      if (u_if.sndRec && !prev) begin
        if (low_cnt < GAP_CYC) gap_viol++;
        n_rise++;
        t_rise = cyc;
        din_ref = u_if.DIN;
      end
      if (!u_if.sndRec && prev) begin n_fall++; t_fall = cyc; end
      if (u_if.sndRec && prev && u_if.DIN !== din_ref) din_viol++;
      low_cnt = u_if.sndRec ? 0 : low_cnt + 1;
      prev = u_if.sndRec;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int maxc, output bit ok);
    int n0 = n_rise;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin step(); if (n_rise != n0) ok = 1'b1; end
  endtask

  task automatic wait_fall(input int maxc, output bit ok);
    int n0 = n_fall;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin step(); if (n_fall != n0) ok = 1'b1; end
  endtask

  task automatic wait_dv(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin step(); if (u_if.dataValid) ok = 1'b1; end
  endtask

  task automatic wait_ack(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin step(); if (u_if.ledAck) ok = 1'b1; end
  endtask

  initial begin
    bit ok;
    int base, t_set, t_led, t1, t2, a0, d0;
    logic [9:0] px, py;
    logic [1:0] pb;

    rst = 1'b1;
    u_if.ledReq = 1'b0;
    u_if.ledR = '0;
    u_if.ledG = '0;
    u_if.ledB = '0;

    // Reset values, before any clock edge.
    #3;
    check_val("rst_sndRec", u_if.sndRec, 0);
    check_val("rst_DIN", u_if.DIN, 0);
    check_val("rst_ledAck", u_if.ledAck, 0);
    check_val("rst_posX", u_if.posX, 0);
    check_val("rst_posY", u_if.posY, 0);
    check_val("rst_btns", u_if.btns, 0);
    check_val("rst_dataValid", u_if.dataValid, 0);
    check_val("rst_err", u_if.err, 0);

    // Idle poll: first tick after POLL_DIV cycles, grant one cycle later.
    resp = 40'h34_02_C1_01_03;
    repeat (3) step();
    base = cyc;
    rst = 1'b0;
    wait_rise(40, ok);
    check_val("poll_rise_seen", ok, 1);
    check_val("poll_rise_time", t_rise - base, POLL_DIV + 1);
    wait_dv(30, ok);
    check_val("poll_dv_seen", ok, 1);
    check_val("poll_dv_latency", cyc - t_ss_rise, 2);
    check_val("poll_posX", u_if.posX, 10'h234);
    check_val("poll_posY", u_if.posY, 10'h1C1);
    check_val("poll_btns", u_if.btns, 2'b11);
    check_val("poll_din", din_seen, 40'h0);
    check_val("poll_ack", u_if.ledAck, 0);
    check_val("poll_dv_count", n_dv, 1);
    check_val("poll_err", u_if.err, 0);

    // LED request.
    resp = 40'h11_01_22_02_01;
    a0 = n_ack;
    u_if.ledR = 8'h12;
    u_if.ledG = 8'h34;
    u_if.ledB = 8'h56;
    u_if.ledReq = 1'b1;
    wait_ack(40, ok);
    check_val("led_ack_seen", ok, 1);
    u_if.ledReq = 1'b0;
    check_val("led_din", din_seen, 40'h84_12_34_56_00);
    check_val("led_dv_with_ack", u_if.dataValid, 1);
    check_val("led_posX", u_if.posX, 10'h111);
    check_val("led_posY", u_if.posY, 10'h222);
    check_val("led_btns", u_if.btns, 2'b01);
    repeat (5) step();
    check_val("led_ack_count", n_ack - a0, 1);

    // Tick and ledReq in the same IDLE cycle: align to a tick-driven read first.
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      bit r;
      wait_rise(40, r);
      if (r && ((t_rise - base) % POLL_DIV) == 1) ok = 1'b1;
    end
    check_val("sim_align", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 2 * POLL_DIV && !ok; i++) begin
      step();
      if (((cyc - base) % POLL_DIV) == POLL_DIV - 1) ok = 1'b1;
    end
    check_val("sim_phase", ok, 1);
    check_val("sim_idle", u_if.sndRec, 0);
    a0 = n_ack;
    d0 = n_dv;
    u_if.ledR = 8'h01;
    u_if.ledG = 8'h02;
    u_if.ledB = 8'h03;
    u_if.ledReq = 1'b1;
    t_set = cyc;
    wait_ack(40, ok);
    check_val("sim_ack_seen", ok, 1);
    u_if.ledReq = 1'b0;
    t_led = t_rise;
    check_val("sim_led_rise", t_led - t_set, 1);
    check_val("sim_led_din", din_seen, 40'h84_01_02_03_00);
    wait_rise(40, ok);
    check_val("sim_next_seen", ok, 1);
    check_val("sim_next_rise", t_rise - t_led, POLL_DIV + 1);
    check_val("sim_ack_count", n_ack - a0, 1);
    check_val("sim_dv_count", n_dv - d0, 1);

    // Timeout: the model never drops SS on the LED transaction.
    wait_dv(40, ok);
    check_val("to_prev_dv", ok, 1);
    px = u_if.posX;
    py = u_if.posY;
    pb = u_if.btns;
    a0 = n_ack;
    hang = 1'b1;
    u_if.ledR = 8'hAA;
    u_if.ledG = 8'hBB;
    u_if.ledB = 8'hCC;
    u_if.ledReq = 1'b1;
    wait_rise(20, ok);
    check_val("to_rise_seen", ok, 1);
    t1 = t_rise;
    check_val("to_din", u_if.DIN, 40'hAA_BB_CC_00 | 40'h84_00_00_00_00);
    wait_fall(40, ok);
    check_val("to_fall_seen", ok, 1);
    t2 = t_fall;
    check_val("to_high_time", t2 - t1, TIMEOUT + 1);
    wait_rise(20, ok);
    check_val("to_retry_seen", ok, 1);
    hang = 1'b0;
    check_val("to_retry_gap", t_rise - t2, GAP_CYC + 2);
    check_val("to_retry_din", u_if.DIN, 40'h84_AA_BB_CC_00);
    check_val("to_err", u_if.err, 1);
    check_val("to_posX_kept", u_if.posX, px);
    check_val("to_posY_kept", u_if.posY, py);
    check_val("to_btns_kept", u_if.btns, pb);
    check_val("to_no_ack", n_ack - a0, 0);
    resp = 40'h55_01_66_03_00;
    wait_ack(40, ok);
    check_val("to_retry_ack", ok, 1);
    u_if.ledReq = 1'b0;
    check_val("to_retry_posX", u_if.posX, 10'h155);
    check_val("to_retry_posY", u_if.posY, 10'h366);
    check_val("to_retry_btns", u_if.btns, 2'b00);
    check_val("to_err_sticky", u_if.err, 1);

    // Reset while in XFER, then a normal poll.
    resp = 40'h7F_03_80_00_02;
    wait_rise(40, ok);
    check_val("rx_rise_seen", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin step(); if (!u_if.SS) ok = 1'b1; end
    check_val("rx_ss_low", ok, 1);
    step();
    rst = 1'b1;
    #1;
    check_val("rx_sndRec", u_if.sndRec, 0);
    check_val("rx_DIN", u_if.DIN, 0);
    check_val("rx_posX", u_if.posX, 0);
    check_val("rx_posY", u_if.posY, 0);
    check_val("rx_btns", u_if.btns, 0);
    check_val("rx_err", u_if.err, 0);
    check_val("rx_dv", u_if.dataValid, 0);
    check_val("rx_ack", u_if.ledAck, 0);
    step();
    base = cyc;
    rst = 1'b0;
    wait_rise(40, ok);
    check_val("rx_poll_seen", ok, 1);
    check_val("rx_poll_rise", t_rise - base, POLL_DIV + 1);
    wait_dv(30, ok);
    check_val("rx_poll_dv", ok, 1);
    check_val("rx_poll_posX", u_if.posX, 10'h37F);
    check_val("rx_poll_posY", u_if.posY, 10'h080);
    check_val("rx_poll_btns", u_if.btns, 2'b10);

    // 100 consecutive polls: gap and DIN stability watched by the monitor.
    gap_viol = 0;
    din_viol = 0;
    d0 = n_dv;
    t1 = 0;
    for (int i = 0; i < 100; i++) begin
      wait_rise(40, ok);
      if (ok) t1++;
    end
    check_val("run_rises", t1, 100);
    wait_dv(30, ok);
    check_val("run_last_dv", ok, 1);
    check_val("run_dv_count", n_dv - d0, 100);
    check_val("run_gap_viol", gap_viol, 0);
    check_val("run_din_viol", din_viol, 0);
    check_val("run_err", u_if.err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
